beverage_dispenser_ctrl: RTL and testbench
==========================================

BEVERAGE_DISPENSER_CTRL -- requirements
Module: beverage_dispenser_ctrl

Interface
REQ-001 Parameter FLAV_W, 2, flavour select width; NUM_FLAV = 2**FLAV_W flavour channels.
REQ-002 Parameter TEMP_W, 8, temperature sample width.
REQ-003 Parameter TEMP_TARGET, 60, milk-ready threshold, unsigned.
REQ-004 Parameter SUGAR_UNIT, 2, SUGAR cycles per sugar level.
REQ-005 Parameter STIR_CYCLES, 2, STIR duration in cycles.
REQ-006 Parameter SYRUP_WAIT, 2, WAIT_SYRUP duration in cycles.
REQ-007 Parameter SYRUP_CYCLES, 3, SYRUP duration in cycles.
REQ-008 Parameter HEAT_TIMEOUT, 200, maximum HEAT cycles before fault.
REQ-009 Parameter CNT_W, 8, phase counter width; all durations SHALL be at most 2**CNT_W-1.
REQ-010 clk  in  1  single clock; all state changes on its rising edge.
REQ-011 rst  in  1  synchronous, active-high reset.
REQ-012 start  in  1  order request, sampled in IDLE only.
REQ-013 ir_sensor  in  1  cup present.
REQ-014 flavour_select  in  FLAV_W  flavour index, latched on accepted start.
REQ-015 sugar_select  in  2  sugar level 0..3, latched on accepted start.
REQ-016 temp_value  in  TEMP_W  milk temperature sample.
REQ-017 fault_clr  in  1  clears FAULT.
REQ-018 busy  out  1  high in every state except IDLE.
REQ-019 water, coffee_powder, sugar, stirrer, heater, whole_milk, milk_dispenser  out  1 each  actuator enables.
REQ-020 syrup_dispenser  out  NUM_FLAV  one-hot syrup enable.
REQ-021 led_flavor  out  NUM_FLAV  one-hot selected-flavour indicator.
REQ-022 led_temp, done, buzzer, fault  out  1 each  status indicators.

Function
REQ-023 States SHALL be IDLE, WAIT_CUP, BREW, SUGAR, STIR, HEAT, DISPENSE_MILK, WAIT_SYRUP, SYRUP, DONE, FAULT; any other encoding SHALL go to IDLE next cycle.
REQ-024 All outputs SHALL be registered and Moore-style: each is a function of the current state register and the latched order only.
REQ-025 IDLE: start=1 latches flavour_select/sugar_select into fl_q/su_q -> WAIT_CUP; inputs changing later SHALL have no effect on the order.
REQ-026 WAIT_CUP: led_flavor = onehot(fl_q) from this state through DONE; ir_sensor=1 -> BREW.
REQ-027 BREW: water=coffee_powder=1 for exactly 1 cycle; su_q=0 -> STIR, else -> SUGAR.
REQ-028 SUGAR: sugar=1 for exactly su_q*SUGAR_UNIT cycles -> STIR.
REQ-029 STIR: stirrer=1 for exactly STIR_CYCLES cycles -> HEAT.
REQ-030 HEAT: heater=whole_milk=stirrer=1; temp_value>=TEMP_TARGET -> DISPENSE_MILK. If that is false after HEAT_TIMEOUT HEAT cycles -> FAULT. Compare SHALL be unsigned; equality counts as ready.
REQ-031 DISPENSE_MILK: milk_dispenser=1 for 1 cycle; led_temp set here and held until leaving DONE -> WAIT_SYRUP.
REQ-032 WAIT_SYRUP: all actuators low for SYRUP_WAIT cycles -> SYRUP.
REQ-033 SYRUP: syrup_dispenser = onehot(fl_q) for exactly SYRUP_CYCLES cycles -> DONE; no other syrup bit SHALL ever assert.
REQ-034 DONE: done=1; buzzer=1 on the first DONE cycle only; ir_sensor=0 -> IDLE; start is ignored.
REQ-035 Cup removal: ir_sensor=0 in any state BREW..SYRUP SHALL go to FAULT on the next edge, overriding the normal transition.
REQ-036 FAULT: fault=buzzer=1; every actuator and syrup_dispenser low; fault_clr=1 -> IDLE; start is ignored.
REQ-037 Simultaneous cup removal and heat timeout or temperature ready SHALL go to FAULT.
REQ-038 The phase counter SHALL clear on every state entry; it SHALL never wrap within a phase.

Reset
REQ-039 rst=1 at any edge, including mid-brew, SHALL force IDLE, clear fl_q, su_q and the counter, and drive every output to 0 on the following cycle.
REQ-040 rst SHALL take priority over all other inputs.

Verification
REQ-041 Defaults; start with flavour=2, sugar=1; cup present; temp 70 -> BREW 1, SUGAR 2, STIR 2, HEAT 1, DISPENSE_MILK 1, WAIT_SYRUP 2, SYRUP 3 cycles with syrup_dispenser=0100; done=1; buzzer for 1 cycle.
REQ-042 sugar=0 -> SUGAR skipped, sugar output never high; sugar=3 -> sugar high exactly 6 cycles.
REQ-043 temp held at 59 -> after 200 HEAT cycles, fault=1 and heater=0; fault_clr -> IDLE.
REQ-044 ir_sensor drops in STIR -> next cycle FAULT, stirrer=0; DONE then cup removed -> IDLE, led_temp=0.
REQ-045 rst pulsed during SYRUP -> all outputs 0 next cycle and state IDLE; flavour_select changed after start -> dispensed flavour unchanged.
REQ-046 temp_value == TEMP_TARGET exactly -> leaves HEAT after 1 cycle.

Source files
------------

// File: rtl/beverage_dispenser_ctrl.sv
// Beverage dispenser sequencer: takes one order, walks the brew/sugar/stir/heat/milk/syrup
// phases with per-phase cycle counts, and faults on cup removal or heater timeout.
module beverage_dispenser_ctrl #(
   parameter int FLAV_W       = 2,
   parameter int TEMP_W       = 8,
   parameter int TEMP_TARGET  = 60,
   parameter int SUGAR_UNIT   = 2,
   parameter int STIR_CYCLES  = 2,
   parameter int SYRUP_WAIT   = 2,
   parameter int SYRUP_CYCLES = 3,
   parameter int HEAT_TIMEOUT = 200,
   parameter int CNT_W        = 8
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     start,
   input  logic                     ir_sensor,
   input  logic [FLAV_W-1:0]        flavour_select,
   input  logic [1:0]               sugar_select,
   input  logic [TEMP_W-1:0]        temp_value,
   input  logic                     fault_clr,
   output logic                     busy,
   output logic                     water,
   output logic                     coffee_powder,
   output logic                     sugar,
   output logic                     stirrer,
   output logic                     heater,
   output logic                     whole_milk,
   output logic                     milk_dispenser,
   output logic [(2**FLAV_W)-1:0]   syrup_dispenser,
   output logic [(2**FLAV_W)-1:0]   led_flavor,
   output logic                     led_temp,
   output logic                     done,
   output logic                     buzzer,
   output logic                     fault
);

   localparam int NUM_FLAV = 2**FLAV_W;

   localparam logic [CNT_W-1:0] STIR_LAST  = CNT_W'(STIR_CYCLES - 1);
   localparam logic [CNT_W-1:0] WAIT_LAST  = CNT_W'(SYRUP_WAIT - 1);
   localparam logic [CNT_W-1:0] SYRUP_LAST = CNT_W'(SYRUP_CYCLES - 1);
   localparam logic [CNT_W-1:0] HEAT_LAST  = CNT_W'(HEAT_TIMEOUT - 1);

   typedef enum logic [3:0] {
      ST_IDLE          = 4'd0,
      ST_WAIT_CUP      = 4'd1,
      ST_BREW          = 4'd2,
      ST_SUGAR         = 4'd3,
      ST_STIR          = 4'd4,
      ST_HEAT          = 4'd5,
      ST_DISPENSE_MILK = 4'd6,
      ST_WAIT_SYRUP    = 4'd7,
      ST_SYRUP         = 4'd8,
      ST_DONE          = 4'd9,
      ST_FAULT         = 4'd10
   } state_t;

   state_t                r_state;
   logic [FLAV_W-1:0]     r_fl;
   logic [1:0]            r_su;
   logic [CNT_W-1:0]      r_cnt;

   state_t                w_nextState;
   logic [FLAV_W-1:0]     w_nextFl;
   logic [NUM_FLAV-1:0]   w_flOneHot;
   logic [CNT_W-1:0]      w_sugarLast;
   logic                  w_tempReady;
   logic                  w_cupGuarded;
   logic                  w_timed;

   assign w_nextFl     = (r_state == ST_IDLE && start) ? flavour_select : r_fl;
   assign w_flOneHot   = NUM_FLAV'(1) << w_nextFl;
   assign w_sugarLast  = CNT_W'(r_su) * CNT_W'(SUGAR_UNIT) - CNT_W'(1);
   assign w_tempReady  = temp_value >= TEMP_W'(TEMP_TARGET);
   assign w_cupGuarded = r_state inside {[ST_BREW:ST_SYRUP]};
   assign w_timed      = r_state inside {ST_SUGAR, ST_STIR, ST_HEAT, ST_WAIT_SYRUP, ST_SYRUP};

   // Cup removal during any dispensing phase beats every other transition.
   always_comb begin
      w_nextState = r_state;
      case (r_state)
         ST_IDLE:          if (start) w_nextState = ST_WAIT_CUP;
         ST_WAIT_CUP:      if (ir_sensor) w_nextState = ST_BREW;
         ST_BREW:          w_nextState = (r_su == 2'd0) ? ST_STIR : ST_SUGAR;
         ST_SUGAR:         if (r_cnt == w_sugarLast) w_nextState = ST_STIR;
         ST_STIR:          if (r_cnt == STIR_LAST) w_nextState = ST_HEAT;
         ST_HEAT: begin
            if (w_tempReady)             w_nextState = ST_DISPENSE_MILK;
            else if (r_cnt == HEAT_LAST) w_nextState = ST_FAULT;
         end
         ST_DISPENSE_MILK: w_nextState = ST_WAIT_SYRUP;
         ST_WAIT_SYRUP:    if (r_cnt == WAIT_LAST) w_nextState = ST_SYRUP;
         ST_SYRUP:         if (r_cnt == SYRUP_LAST) w_nextState = ST_DONE;
         ST_DONE:          if (!ir_sensor) w_nextState = ST_IDLE;
         ST_FAULT:         if (fault_clr) w_nextState = ST_IDLE;
         default:          w_nextState = ST_IDLE;
      endcase
      if (w_cupGuarded && !ir_sensor) w_nextState = ST_FAULT;
   end

   // Outputs are decoded from the state being entered so they line up with r_state.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state         <= ST_IDLE;
         r_fl            <= '0;
         r_su            <= '0;
         r_cnt           <= '0;
         busy            <= 1'b0;
         water           <= 1'b0;
         coffee_powder   <= 1'b0;
         sugar           <= 1'b0;
         stirrer         <= 1'b0;
         heater          <= 1'b0;
         whole_milk      <= 1'b0;
         milk_dispenser  <= 1'b0;
         syrup_dispenser <= '0;
         led_flavor      <= '0;
         led_temp        <= 1'b0;
         done            <= 1'b0;
         buzzer          <= 1'b0;
         fault           <= 1'b0;
      end else begin
         r_state <= w_nextState;
         if (r_state == ST_IDLE && start) begin
            r_fl <= flavour_select;
            r_su <= sugar_select;
         end
         if (w_nextState != r_state)
            r_cnt <= '0;
         else if (w_timed)
            r_cnt <= r_cnt + CNT_W'(1);

         busy            <= (w_nextState != ST_IDLE);
         water           <= (w_nextState == ST_BREW);
         coffee_powder   <= (w_nextState == ST_BREW);
         sugar           <= (w_nextState == ST_SUGAR);
         stirrer         <= (w_nextState == ST_STIR) || (w_nextState == ST_HEAT);
         heater          <= (w_nextState == ST_HEAT);
         whole_milk      <= (w_nextState == ST_HEAT);
         milk_dispenser  <= (w_nextState == ST_DISPENSE_MILK);
         syrup_dispenser <= (w_nextState == ST_SYRUP) ? w_flOneHot : '0;
         led_flavor      <= (w_nextState inside {[ST_WAIT_CUP:ST_DONE]}) ? w_flOneHot : '0;
         led_temp        <= (w_nextState inside {[ST_DISPENSE_MILK:ST_DONE]});
         done            <= (w_nextState == ST_DONE);
         buzzer          <= ((w_nextState == ST_DONE) && (r_state != ST_DONE)) ||
                            (w_nextState == ST_FAULT);
         fault           <= (w_nextState == ST_FAULT);
      end
   end

endmodule

// File: tb/tb_beverage_dispenser_ctrl.sv
// Self-checking bench for beverage_dispenser_ctrl: each order is expanded into a per-cycle
// phase timeline from the recipe durations, then replayed against the DUT cycle by cycle.
module tb_beverage_dispenser_ctrl;

   localparam int PH_IDLE  = 0;
   localparam int PH_WAIT  = 1;
   localparam int PH_BREW  = 2;
   localparam int PH_SUGAR = 3;
   localparam int PH_STIR  = 4;
   localparam int PH_HEAT  = 5;
   localparam int PH_MILK  = 6;
   localparam int PH_WSYR  = 7;
   localparam int PH_SYR   = 8;
   localparam int PH_DONE  = 9;
   localparam int PH_FAULT = 10;

   typedef struct packed {
      logic       ir;
      logic [7:0] temp;
      logic       st;
      logic       clr;
      logic       rs;
      logic [1:0] fsel;
      logic [1:0] ssel;
   } drv_t;

   logic       clk = 1'b0;
   logic       rst;
   logic       start;
   logic       ir_sensor;
   logic [1:0] flavour_select;
   logic [1:0] sugar_select;
   logic [7:0] temp_value;
   logic       fault_clr;
   logic       busy, water, coffee_powder, sugar, stirrer, heater, whole_milk, milk_dispenser;
   logic [3:0] syrup_dispenser;
   logic [3:0] led_flavor;
   logic       led_temp, done, buzzer, fault;

   logic [19:0] w_obs;
   int nCompared   = 0;
   int nMismatched = 0;
   int orderNo     = 0;
   string phName [11] = '{"IDLE", "WAIT_CUP", "BREW", "SUGAR", "STIR", "HEAT",
                          "MILK", "WAIT_SYRUP", "SYRUP", "DONE", "FAULT"};

   int   phQ[$];
   drv_t dQ[$];

   beverage_dispenser_ctrl dut (
      .clk             (clk),
      .rst             (rst),
      .start           (start),
      .ir_sensor       (ir_sensor),
      .flavour_select  (flavour_select),
      .sugar_select    (sugar_select),
      .temp_value      (temp_value),
      .fault_clr       (fault_clr),
      .busy            (busy),
      .water           (water),
      .coffee_powder   (coffee_powder),
      .sugar           (sugar),
      .stirrer         (stirrer),
      .heater          (heater),
      .whole_milk      (whole_milk),
      .milk_dispenser  (milk_dispenser),
      .syrup_dispenser (syrup_dispenser),
      .led_flavor      (led_flavor),
      .led_temp        (led_temp),
      .done            (done),
      .buzzer          (buzzer),
      .fault           (fault)
   );

   always #5 clk = ~clk;

   assign w_obs = {busy, water, coffee_powder, sugar, stirrer, heater, whole_milk, milk_dispenser,
                   syrup_dispenser, led_flavor, led_temp, done, buzzer, fault};

   // Expected output word for one cycle spent in a given phase of the recipe.
   function automatic logic [19:0] expectedOutputs(input int ph, input logic [1:0] fl,
                                                   input bit firstDone);
      logic [3:0] oh, syr, led;
      logic bsy, wat, cof, sug, sti, hea, whm, mil, lt, dn, bz, flt;
      oh  = 4'b0001 << fl;
      bsy = (ph != PH_IDLE);
      wat = (ph == PH_BREW);
      cof = (ph == PH_BREW);
      sug = (ph == PH_SUGAR);
      sti = (ph == PH_STIR) || (ph == PH_HEAT);
      hea = (ph == PH_HEAT);
      whm = (ph == PH_HEAT);
      mil = (ph == PH_MILK);
      syr = (ph == PH_SYR) ? oh : 4'b0000;
      led = (ph >= PH_WAIT && ph <= PH_DONE) ? oh : 4'b0000;
      lt  = (ph >= PH_MILK && ph <= PH_DONE);
      dn  = (ph == PH_DONE);
      bz  = (ph == PH_FAULT) || (ph == PH_DONE && firstDone);
      flt = (ph == PH_FAULT);
      return {bsy, wat, cof, sug, sti, hea, whm, mil, syr, led, lt, dn, bz, flt};
   endfunction

   function automatic drv_t randomDrive();
      drv_t d;
      d.ir   = 1'($urandom_range(0, 1));
      d.temp = 8'($urandom_range(0, 255));
      d.st   = 1'($urandom_range(0, 1));
      d.clr  = 1'b0;
      d.rs   = 1'b0;
      d.fsel = 2'($urandom_range(0, 3));
      d.ssel = 2'($urandom_range(0, 3));
      return d;
   endfunction

   task automatic applyStimulus(input drv_t d);
      ir_sensor      = d.ir;
      temp_value     = d.temp;
      start          = d.st;
      fault_clr      = d.clr;
      rst            = d.rs;
      flavour_select = d.fsel;
      sugar_select   = d.ssel;
   endtask

   task automatic checkOutput(input string tag, input logic [19:0] got, input logic [19:0] exp);
      nCompared++;
      if (got !== exp) begin
         nMismatched++;
         $display("[TB] FAIL %s: got %05h expected %05h", tag, got, exp);
      end
   endtask

   // Build the cycle timeline of one order, then drive it and compare every cycle.
   task automatic runOrder(input logic [1:0] fl, input logic [1:0] su, input int waitCup,
                           input int heatReady, input logic [7:0] readyTemp,
                           input int removeAt, input int resetAt);
      int   core[$];
      int   heatIdx;
      int   term;
      int   n;
      drv_t d;
      bit   firstDone;

      orderNo++;
      phQ.delete();
      dQ.delete();
      for (int i = 0; i <= waitCup; i++) begin
         phQ.push_back(PH_WAIT);
         d    = randomDrive();
         d.ir = (i == waitCup);
         dQ.push_back(d);
      end

      core.push_back(PH_BREW);
      for (int i = 0; i < int'(su) * 2; i++) core.push_back(PH_SUGAR);
      repeat (2) core.push_back(PH_STIR);
      for (int i = 0; i < ((heatReady > 0) ? heatReady : 200); i++) core.push_back(PH_HEAT);
      if (heatReady > 0) begin
         core.push_back(PH_MILK);
         repeat (2) core.push_back(PH_WSYR);
         repeat (3) core.push_back(PH_SYR);
      end

      term    = (heatReady > 0) ? PH_DONE : PH_FAULT;
      heatIdx = 0;
      for (int i = 0; i < core.size(); i++) begin
         phQ.push_back(core[i]);
         d    = randomDrive();
         d.ir = 1'b1;
         if (core[i] == PH_HEAT) begin
            heatIdx++;
            d.temp = (heatIdx == heatReady) ? readyTemp : 8'($urandom_range(0, 59));
         end
         if (i == resetAt) begin
            d.rs = 1'b1;
            d.ir = 1'($urandom_range(0, 1));
            dQ.push_back(d);
            term = PH_IDLE;
            break;
         end
         if (i == removeAt) begin
            d.ir = 1'b0;
            dQ.push_back(d);
            term = PH_FAULT;
            break;
         end
         dQ.push_back(d);
      end

      n = $urandom_range(1, 3);
      if (term == PH_DONE) begin
         for (int i = 0; i < n; i++) begin
            phQ.push_back(PH_DONE);
            d    = randomDrive();
            d.ir = (i != n - 1);
            dQ.push_back(d);
         end
      end else if (term == PH_FAULT) begin
         for (int i = 0; i < n; i++) begin
            phQ.push_back(PH_FAULT);
            d     = randomDrive();
            d.clr = (i == n - 1);
            dQ.push_back(d);
         end
      end
      phQ.push_back(PH_IDLE);

      d      = randomDrive();
      d.st   = 1'b1;
      d.ir   = 1'b0;
      d.fsel = fl;
      d.ssel = su;
      applyStimulus(d);
      @(posedge clk);
      for (int k = 0; k < phQ.size(); k++) begin
         @(negedge clk);
         firstDone = (k == 0) ? 1'b1 : (phQ[k-1] != PH_DONE);
         checkOutput($sformatf("ord%0d_c%0d_%s", orderNo, k, phName[phQ[k]]), w_obs,
                     expectedOutputs(phQ[k], fl, firstDone));
         if (k < dQ.size()) begin
            applyStimulus(dQ[k]);
            @(posedge clk);
         end
      end
      d    = randomDrive();
      d.st = 1'b0;
      applyStimulus(d);
   endtask

   initial begin
      int heatReady, removeAt, resetAt, coreLen;
      logic [1:0] fl, su;

      rst = 1'b1; start = 1'b0; ir_sensor = 1'b0; flavour_select = 2'd0;
      sugar_select = 2'd0; temp_value = 8'd0; fault_clr = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      checkOutput("reset_idle", w_obs, 20'h0);
      start = 1'b1; ir_sensor = 1'b1; flavour_select = 2'd3; sugar_select = 2'd3;
      @(posedge clk);
      @(negedge clk);
      checkOutput("reset_priority", w_obs, 20'h0);
      rst = 1'b0; start = 1'b0;

      // Directed recipes: nominal, sugar corners, exact threshold, timeout, removals, reset.
      runOrder(2'd2, 2'd1, 1, 1, 8'd70,  -1, -1);
      runOrder(2'd1, 2'd0, 0, 2, 8'd200, -1, -1);
      runOrder(2'd3, 2'd3, 0, 1, 8'd60,  -1, -1);
      runOrder(2'd0, 2'd2, 0, 0, 8'd0,   -1, -1);
      runOrder(2'd2, 2'd1, 0, 1, 8'd90,   3, -1);
      runOrder(2'd1, 2'd0, 0, 1, 8'd100, -1,  8);
      runOrder(2'd0, 2'd0, 0, 3, 8'd61,   5, -1);
      runOrder(2'd3, 2'd0, 0, 0, 8'd0,  202, -1);
      runOrder(2'd1, 2'd1, 2, 200, 8'd255, -1, -1);

      for (int t = 0; t < 30; t++) begin
         fl        = 2'($urandom_range(0, 3));
         su        = 2'($urandom_range(0, 3));
         heatReady = ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(1, 6);
         coreLen   = 1 + int'(su) * 2 + 2 + ((heatReady > 0) ? heatReady + 6 : 200);
         removeAt  = ($urandom_range(0, 3) == 0) ? $urandom_range(0, coreLen - 1) : -1;
         resetAt   = ($urandom_range(0, 7) == 0) ? $urandom_range(0, coreLen - 1) : -1;
         runOrder(fl, su, $urandom_range(0, 2), heatReady, 8'($urandom_range(60, 255)),
                  removeAt, resetAt);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
      $finish;
   end

endmodule
